// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared definitions for the ASCON-128 control FSM: state encoding, round/block defaults
// and the IV constant consumed by the datapath state mux.
package ascon_ctrl_fsm_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      WAIT_AD,
      AD,
      WAIT_PT,
      PT,
      WAIT_LAST,
      FINAL,
      DONE
   } fsm_state_t;

   localparam int NB_BLOCKS_DEF = 4;
   localparam int ROUNDS_A_DEF  = 12;
   localparam int ROUNDS_B_DEF  = 6;

   localparam logic [3:0]  LAST_ROUND = 4'd11;
   localparam logic [63:0] ASCON_IV   = 64'h80400C0600000000;

   // Permutation rounds are the only states in which the state register loads.
   function automatic logic is_round_state(input fsm_state_t s);
      return (s == INIT) || (s == AD) || (s == PT) || (s == FINAL);
   endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Round index counter for the ASCON permutation: loadable start round, saturates at the
// last round (11) so it can never wrap into 12..15.
module ascon_round_counter
   import ascon_ctrl_fsm_pkg::*;
(
   input  logic       clock,
   input  logic       resetb,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       en,
   output logic [3:0] count,
   output logic       last
);

   assign last = (count == LAST_ROUND);

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !last) begin
         count <= count + 4'd1;
      end
   end

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption control FSM: init pa, one AD block, NB_BLOCKS plaintext blocks, final pa.
// Optional synchronous abort input enabled by defining ASCON_CTRL_ABORT_EN.
module ascon_ctrl_fsm
   import ascon_ctrl_fsm_pkg::*;
#(
   parameter int NB_BLOCKS = NB_BLOCKS_DEF,
   parameter int ROUNDS_A  = ROUNDS_A_DEF,
   parameter int ROUNDS_B  = ROUNDS_B_DEF
)
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       data_valid_i,
`ifdef ASCON_CTRL_ABORT_EN
   input  logic       abort_i,
`endif
   output logic [3:0] round_o,
   output logic       sel_init_o,
   output logic       en_state_o,
   output logic       en_xor_data_o,
   output logic       en_xor_key_begin_o,
   output logic       en_xor_key_end_o,
   output logic       en_xor_lsb_end_o,
   output logic       en_cipher_o,
   output logic       en_tag_o,
   output logic       cipher_valid_o,
   output logic [3:0] block_o,
   output logic       end_o
);

   localparam logic [3:0] FIRST_A       = 4'(12 - ROUNDS_A);
   localparam logic [3:0] FIRST_B       = 4'(12 - ROUNDS_B);
   localparam logic [3:0] LAST_PT_BLOCK = 4'((NB_BLOCKS >= 2) ? (NB_BLOCKS - 2) : 0);

   fsm_state_t state;
   fsm_state_t next_state;
   logic [3:0] round_cnt;
   logic       round_last;
   logic       cnt_load;
   logic [3:0] cnt_load_val;
   logic [3:0] block_cnt;
   logic       in_rounds;
   logic       first_a;
   logic       first_b;
   logic       abort;
   logic       end_q;
   logic       cipher_valid_q;

`ifdef ASCON_CTRL_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   assign in_rounds = is_round_state(state);
   assign first_a   = (round_cnt == FIRST_A);
   assign first_b   = (round_cnt == FIRST_B);

   ascon_round_counter u_round_counter (
      .clock    (clock_i),
      .resetb   (resetb_i),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (in_rounds),
      .count    (round_cnt),
      .last     (round_last)
   );

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state          <= IDLE;
         end_q          <= 1'b0;
         cipher_valid_q <= 1'b0;
      end else begin
         state          <= next_state;
         end_q          <= (next_state == DONE);
         cipher_valid_q <= en_cipher_o && !abort;
      end
   end

   // Block index restarts with each message and advances as each full PT block finishes.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         block_cnt <= '0;
      end else if (abort) begin
         block_cnt <= '0;
      end else if (((state == IDLE) || (state == DONE)) && start_i) begin
         block_cnt <= '0;
      end else if ((state == PT) && round_last) begin
         block_cnt <= block_cnt + 4'd1;
      end
   end

   always_comb begin
      next_state         = state;
      cnt_load           = 1'b0;
      cnt_load_val       = '0;
      round_o            = in_rounds ? round_cnt : 4'd0;
      sel_init_o         = 1'b0;
      en_state_o         = in_rounds;
      en_xor_data_o      = 1'b0;
      en_xor_key_begin_o = 1'b0;
      en_xor_key_end_o   = 1'b0;
      en_xor_lsb_end_o   = 1'b0;
      en_cipher_o        = 1'b0;
      en_tag_o           = 1'b0;

      unique case (state)
         IDLE, DONE: begin
            if (start_i) begin
               next_state   = INIT;
               cnt_load     = 1'b1;
               cnt_load_val = FIRST_A;
            end
         end
         INIT: begin
            sel_init_o       = first_a;
            en_xor_key_end_o = round_last;
            if (round_last) next_state = WAIT_AD;
         end
         WAIT_AD: begin
            if (data_valid_i) begin
               next_state   = AD;
               cnt_load     = 1'b1;
               cnt_load_val = FIRST_B;
            end
         end
         AD: begin
            en_xor_data_o    = first_b;
            en_xor_lsb_end_o = round_last;
            if (round_last) next_state = (NB_BLOCKS == 1) ? WAIT_LAST : WAIT_PT;
         end
         WAIT_PT: begin
            if (data_valid_i) begin
               next_state   = PT;
               cnt_load     = 1'b1;
               cnt_load_val = FIRST_B;
            end
         end
         PT: begin
            en_xor_data_o = first_b;
            en_cipher_o   = first_b;
            if (round_last) next_state = (block_cnt == LAST_PT_BLOCK) ? WAIT_LAST : WAIT_PT;
         end
         WAIT_LAST: begin
            if (data_valid_i) begin
               next_state   = FINAL;
               cnt_load     = 1'b1;
               cnt_load_val = FIRST_A;
            end
         end
         FINAL: begin
            en_xor_data_o      = first_a;
            en_cipher_o        = first_a;
            en_xor_key_begin_o = first_a;
            en_xor_key_end_o   = round_last;
            en_tag_o           = round_last;
            if (round_last) next_state = DONE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      // Abort takes effect on the next edge exactly like reset, clearing the round counter too.
      if (abort) begin
         next_state   = IDLE;
         cnt_load     = 1'b1;
         cnt_load_val = '0;
      end
   end

   assign block_o        = block_cnt;
   assign end_o          = end_q;
   assign cipher_valid_o = cipher_valid_q;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed self-checking bench for ascon_ctrl_fsm (NB_BLOCKS=4, ROUNDS_A=12, ROUNDS_B=6).
// Exercises the abort input as well when ASCON_CTRL_ABORT_EN is defined.
module tb_ascon_ctrl_fsm;

   localparam logic [9:0] F_SEL    = 10'h200;
   localparam logic [9:0] F_STATE  = 10'h100;
   localparam logic [9:0] F_XDATA  = 10'h080;
   localparam logic [9:0] F_KEYBEG = 10'h040;
   localparam logic [9:0] F_KEYEND = 10'h020;
   localparam logic [9:0] F_LSB    = 10'h010;
   localparam logic [9:0] F_CIPHER = 10'h008;
   localparam logic [9:0] F_TAG    = 10'h004;
   localparam logic [9:0] F_CVALID = 10'h002;
   localparam logic [9:0] F_END    = 10'h001;
   localparam logic [9:0] F_NONE   = 10'h000;

   logic       clock_i;
   logic       resetb_i;
   logic       start_i;
   logic       data_valid_i;
`ifdef ASCON_CTRL_ABORT_EN
   logic       abort_i;
`endif
   logic [3:0] round_o;
   logic       sel_init_o;
   logic       en_state_o;
   logic       en_xor_data_o;
   logic       en_xor_key_begin_o;
   logic       en_xor_key_end_o;
   logic       en_xor_lsb_end_o;
   logic       en_cipher_o;
   logic       en_tag_o;
   logic       cipher_valid_o;
   logic [3:0] block_o;
   logic       end_o;

   int assertCount = 0;
   int failCount   = 0;
   int cycCount    = 0;

   ascon_ctrl_fsm dut (
      .clock_i            (clock_i),
      .resetb_i           (resetb_i),
      .start_i            (start_i),
      .data_valid_i       (data_valid_i),
`ifdef ASCON_CTRL_ABORT_EN
      .abort_i            (abort_i),
`endif
      .round_o            (round_o),
      .sel_init_o         (sel_init_o),
      .en_state_o         (en_state_o),
      .en_xor_data_o      (en_xor_data_o),
      .en_xor_key_begin_o (en_xor_key_begin_o),
      .en_xor_key_end_o   (en_xor_key_end_o),
      .en_xor_lsb_end_o   (en_xor_lsb_end_o),
      .en_cipher_o        (en_cipher_o),
      .en_tag_o           (en_tag_o),
      .cipher_valid_o     (cipher_valid_o),
      .block_o            (block_o),
      .end_o              (end_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   function automatic logic [31:0] obsVec();
      return {14'b0, block_o, round_o, sel_init_o, en_state_o, en_xor_data_o, en_xor_key_begin_o,
              en_xor_key_end_o, en_xor_lsb_end_o, en_cipher_o, en_tag_o, cipher_valid_o, end_o};
   endfunction

   function automatic logic [31:0] packExp(input int blk, input int rnd, input logic [9:0] flags);
      logic [3:0] b;
      logic [3:0] r;
      b = blk[3:0];
      r = rnd[3:0];
      return {14'b0, b, r, flags};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One WAIT_x state: data_valid held low for 'hold' cycles, then raised for one cycle.
   task automatic waitPhase(input int hold, input int blk, input string tag);
      if (hold > 0) data_valid_i = 1'b0;
      for (int w = 0; w < hold; w++) begin
         checkOutput({tag, "_wait"}, obsVec(), packExp(blk, 0, F_NONE));
         @(negedge clock_i);
         cycCount++;
      end
      data_valid_i = 1'b1;
      checkOutput({tag, "_wait"}, obsVec(), packExp(blk, 0, F_NONE));
      @(negedge clock_i);
      cycCount++;
   endtask

   // Full message from IDLE or DONE; checks every cycle and the start-to-end_o latency.
   task automatic applyStimulus(input int hold, input bit toggleStart, input string tag);
      int expLatency;
      start_i      = 1'b1;
      data_valid_i = (hold == 0);
      @(negedge clock_i);
      start_i  = 1'b0;
      cycCount = 0;
      for (int r = 0; r < 12; r++) begin
         if (toggleStart) start_i = r[0];
         checkOutput({tag, "_init"}, obsVec(),
                     packExp(0, r, F_STATE | ((r == 0) ? F_SEL : F_NONE) | ((r == 11) ? F_KEYEND : F_NONE)));
         @(negedge clock_i);
         cycCount++;
      end
      start_i = 1'b0;
      waitPhase(hold, 0, tag);
      for (int r = 6; r < 12; r++) begin
         checkOutput({tag, "_ad"}, obsVec(),
                     packExp(0, r, F_STATE | ((r == 6) ? F_XDATA : F_NONE) | ((r == 11) ? F_LSB : F_NONE)));
         @(negedge clock_i);
         cycCount++;
      end
      for (int b = 0; b < 3; b++) begin
         waitPhase(hold, b, tag);
         for (int r = 6; r < 12; r++) begin
            if (toggleStart) start_i = r[0];
            checkOutput({tag, "_pt"}, obsVec(),
                        packExp(b, r, F_STATE | ((r == 6) ? (F_XDATA | F_CIPHER) : F_NONE) |
                                      ((r == 7) ? F_CVALID : F_NONE)));
            @(negedge clock_i);
            cycCount++;
         end
         start_i = 1'b0;
      end
      waitPhase(hold, 3, tag);
      for (int r = 0; r < 12; r++) begin
         checkOutput({tag, "_final"}, obsVec(),
                     packExp(3, r, F_STATE | ((r == 0) ? (F_XDATA | F_CIPHER | F_KEYBEG) : F_NONE) |
                                   ((r == 1) ? F_CVALID : F_NONE) | ((r == 11) ? (F_KEYEND | F_TAG) : F_NONE)));
         @(negedge clock_i);
         cycCount++;
      end
      checkOutput({tag, "_done"}, obsVec(), packExp(3, 0, F_END));
      // 12 + 6 + 6*3 + 12 round cycles plus five wait states (AD, three PT, last block)
      expLatency = 12 + 6 + 6 * 3 + 12 + 5 * (hold + 1);
      checkOutput({tag, "_latency"}, 32'(cycCount), 32'(expLatency));
   endtask

   initial begin
      resetb_i     = 1'b0;
      start_i      = 1'b0;
      data_valid_i = 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
      abort_i      = 1'b0;
`endif
      #1;
      checkOutput("reset_state", obsVec(), 32'h0);
      @(negedge clock_i);
      @(negedge clock_i);
      resetb_i = 1'b1;
      @(negedge clock_i);
      checkOutput("idle_after_reset", obsVec(), 32'h0);

      applyStimulus(0, 1'b0, "run1");
      for (int i = 0; i < 3; i++) begin
         @(negedge clock_i);
         checkOutput("done_hold", obsVec(), packExp(3, 0, F_END));
      end
      applyStimulus(0, 1'b0, "rerun");
      applyStimulus(5, 1'b0, "hold");
      applyStimulus(0, 1'b1, "toggle");

      // Asynchronous reset in PT block 2, round 8 (36 cycles after the first INIT cycle)
      start_i      = 1'b1;
      data_valid_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
      repeat (36) @(negedge clock_i);
      checkOutput("rst_pre", obsVec(), packExp(2, 8, F_STATE));
      #2 resetb_i = 1'b0;
      #1;
      checkOutput("rst_async", obsVec(), 32'h0);
      @(negedge clock_i);
      checkOutput("rst_hold", obsVec(), 32'h0);
      resetb_i = 1'b1;
      @(negedge clock_i);
      checkOutput("rst_idle", obsVec(), 32'h0);

`ifdef ASCON_CTRL_ABORT_EN
      start_i = 1'b1;
      @(negedge clock_i);
      start_i = 1'b0;
      repeat (46) @(negedge clock_i);
      checkOutput("abort_pre", obsVec(), packExp(3, 5, F_STATE));
      abort_i = 1'b1;
      @(negedge clock_i);
      abort_i = 1'b0;
      checkOutput("abort_idle", obsVec(), 32'h0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clock_i);
         checkOutput("abort_no_tag", obsVec(), 32'h0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
